read_response_handler: RTL and testbench
========================================

# read_response_handler

Consumes CCI-P channel-0 read responses, the downstream partner of the read engine. Routes each response by mdata:
- Control-poll lines are decoded onto the `ctrl_resp` interface.
- Run-data responses are counted toward run completion.

It also tracks outstanding reads and produces the `stall` that throttles read issue.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 64: read-credit limit (power of two, ≥8).
- `STALL_MARGIN`, 4: headroom for reads already in the issuer pipeline.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `afu_state`  in  `e_afu_state`  current AFU state.
- `rd_issued`  in  1  a read request was sent this cycle (the read engine's registered `rd_valid`).
- `tx_almfull`  in  1  channel-0 TX almost-full.
- `rx_valid`  in  1  channel-0 read response valid.
- `rx_mdata`  in  `t_cci_mdata`  response mdata.
- `rx_data`  in  512  response cache line.
- `ctrl_resp`  modport `to_host`  fields:
  - `valid`, `ack`: 1 bit each.
  - `code`: `t_uint32`.
  - `rd_addr`: `t_cci_clAddr`.
  - `num_cls`: `t_uint32`.
- `stall`  out  1  stop issuing reads.
- `run_rsp_count`  out  32  run responses received in the current run.
- `run_complete`  out  1  one-cycle pulse when the run's last response arrives.
- `err_unexpected`  out  1  sticky error; cleared only by reset.

## Operation
- Control line layout:
  - `code`: `rx_data[31:0]`.
  - `num_cls`: `rx_data[63:32]`.
  - `rd_addr`: `rx_data[64 +: $bits(t_cci_clAddr)]`.
  - Remaining bits are ignored.
- Response with `rx_mdata == READ_CTRL_MDATA`:
  - `ack` pulses for 1 cycle.
  - If `code != CONTROL_NOP`: `valid` pulses in the same cycle, and `code`/`rd_addr`/`num_cls` hold the decoded values until the next control response.
- `valid` with `code == CONTROL_START_RUN`:
  - Latch `expected = num_cls + 1`, computed in 33 bits so there is no wrap at 0xFFFFFFFF. One extra line is counted because the issuer covers `start..start+num_cls` inclusive.
  - Clear `run_rsp_count`.
- Response with `rx_mdata == READ_RUN_MDATA`:
  - Increment `run_rsp_count`; the counter saturates at 0xFFFFFFFF.
  - When the new count equals `expected`: pulse `run_complete`.
  - Responses beyond `expected`: still counted, set `err_unexpected`, no second `run_complete` pulse.
- Response with any other mdata: dropped and sets `err_unexpected`. The response still counts toward outstanding.
- Outstanding counter, `$clog2(MAX_OUTSTANDING)+1` bits:
  - +1 on `rd_issued`; −1 on `rx_valid`; both in the same cycle gives no change.
  - A decrement at 0 holds the counter at 0 and sets `err_unexpected`.
- `stall = tx_almfull_q | (outstanding >= MAX_OUTSTANDING - STALL_MARGIN)`.
- `afu_state` other than `AFU_CTRL` or `AFU_RUN`:
  - Control and run responses are still processed, so stragglers drain.
  - `run_complete` is suppressed.
- Reset values:
  - `ctrl_resp.valid`, `ack`, `code`, `rd_addr`, `num_cls`: 0.
  - `stall`: 1.
  - `run_rsp_count`, `run_complete`, `err_unexpected`: 0.
  - Outstanding counter and `expected`: 0.
- Reset asserted mid-run: all state clears immediately. Responses arriving after reset deasserts are unexpected.

## Timing
- Stage 1 registers `rx_valid`/`rx_mdata`/`rx_data`; stage 2 decodes and drives outputs.
- Latency from `rx_valid` (cycle N) to `ack`/`valid`/`run_complete`/`run_rsp_count` update: cycle N+2.
- `stall` is registered:
  - It reflects the counter value one cycle after a `rd_issued`/`rx_valid` event.
  - It reflects `tx_almfull` one cycle after it changes.
  - `STALL_MARGIN` covers this delay plus the issuer pipeline.
- `stall` deasserts 1 cycle after `rst_n` rises, provided `tx_almfull` is low.
- Back-to-back responses are accepted every cycle; there is no backpressure on RX.

## Structure
- Package `interface_debug` holds:
  - `CONTROL_NOP` = 0, `CONTROL_START_RUN` = 1, `CONTROL_STOP` = 2.
  - `READ_CTRL_MDATA`, `READ_RUN_MDATA`.
  - The control-line field offsets.
- `e_afu_state` and `t_uint32` come from `afu_base`.
- Sub-module `credit_counter`: the up/down saturating counter with threshold compare and underflow flag, parameterised by `MAX_OUTSTANDING`/`STALL_MARGIN`.

## Test plan
- Control line with code = 1, rd_addr = 0x1000, num_cls = 7 → at N+2: `ack` = 1, `valid` = 1, and fields match. Then 8 run responses → `run_complete` pulses on the 8th; `run_rsp_count` = 8.
- Control line with code = 0 → `ack` pulses, `valid` stays 0, and previous field values are held.
- Issue 60 reads with no responses (`MAX_OUTSTANDING` = 64, `STALL_MARGIN` = 4) → `stall` = 1 from the cycle after the 60th. One response → `stall` = 0 the next cycle. Simultaneous issue and response → the counter is unchanged.
- Response with mdata = 0xBEEF, and separately an `rx_valid` with 0 outstanding → `err_unexpected` = 1 and stays 1; the outstanding counter remains 0.
- START_RUN with num_cls = 0xFFFFFFFF → `expected` does not wrap; no `run_complete` after 1 response.
- Assert `rst_n` low mid-run with 10 outstanding → all outputs return to reset values immediately (`stall` = 1); after release, `stall` = 0 and the counter reads 0.

Source files
------------

// File: rtl/read_response_handler_pkg.sv
// Shared types and constants for the channel-0 read response path.
// Holds the AFU base types, the control-line layout and the handler's pipeline stage type.
package afu_base;
    typedef logic [31:0] t_uint32;
    typedef logic [15:0] t_cci_mdata;
    typedef logic [41:0] t_cci_clAddr;

    typedef enum logic [1:0] {
        AFU_IDLE = 2'd0,
        AFU_CTRL = 2'd1,
        AFU_RUN  = 2'd2,
        AFU_DONE = 2'd3
    } e_afu_state;
endpackage

package interface_debug;
    import afu_base::*;

    localparam t_uint32 CONTROL_NOP       = 32'd0;
    localparam t_uint32 CONTROL_START_RUN = 32'd1;
    localparam t_uint32 CONTROL_STOP      = 32'd2;

    localparam t_cci_mdata READ_CTRL_MDATA = 16'h0001;
    localparam t_cci_mdata READ_RUN_MDATA  = 16'h0002;

    localparam int CTRL_CODE_LSB    = 0;
    localparam int CTRL_NUM_CLS_LSB = 32;
    localparam int CTRL_RD_ADDR_LSB = 64;
endpackage

package read_response_handler_pkg;
    import afu_base::*;

    // Only the control fields of a line are kept past the input register.
    typedef struct packed {
        logic        valid;
        t_cci_mdata  mdata;
        t_uint32     code;
        t_uint32     num_cls;
        t_cci_clAddr rd_addr;
    } t_rx_stage;

    function automatic logic completion_allowed(input e_afu_state state);
        return (state == AFU_CTRL) || (state == AFU_RUN);
    endfunction
endpackage

// File: rtl/ctrl_resp_if.sv
// Decoded control-poll response presented to the host-control logic.
interface ctrl_resp_if;
    import afu_base::*;

    logic        valid;
    logic        ack;
    t_uint32     code;
    t_cci_clAddr rd_addr;
    t_uint32     num_cls;

    modport to_host   (output valid, ack, code, rd_addr, num_cls);
    modport from_host (input  valid, ack, code, rd_addr, num_cls);
endinterface

// File: rtl/read_response_handler_credit_counter.sv
// Outstanding-read tracker: saturating up/down counter with a registered stall threshold.
module credit_counter #(
    parameter int MAX_OUTSTANDING = 64,
    parameter int STALL_MARGIN    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             inc,
    input  logic                             dec,
    input  logic                             almfull,
    output logic [$clog2(MAX_OUTSTANDING):0] count,
    output logic                             stall,
    output logic                             underflow
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] THRESHOLD = CW'(MAX_OUTSTANDING - STALL_MARGIN);
    localparam logic [CW-1:0] COUNT_MAX = '1;

    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count;
        underflow  = 1'b0;
        if (inc && !dec) begin
            if (count != COUNT_MAX) count_next = count + CW'(1);
        end else if (dec && !inc) begin
            if (count == '0) underflow = 1'b1;
            else             count_next = count - CW'(1);
        end
    end

    // Stall is derived from the next count so it lines up with the registered counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            stall <= 1'b1;
        end else begin
            count <= count_next;
            stall <= almfull | (count_next >= THRESHOLD);
        end
    end
endmodule

// File: rtl/read_response_handler.sv
// Routes channel-0 read responses by mdata: control lines to ctrl_resp, run data to the
// run completion counter; also tracks outstanding reads to throttle the read issuer.
module read_response_handler
    import afu_base::*;
    import interface_debug::*;
    import read_response_handler_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 64,
    parameter int STALL_MARGIN    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  e_afu_state          afu_state,
    input  logic                rd_issued,
    input  logic                tx_almfull,
    input  logic                rx_valid,
    input  t_cci_mdata          rx_mdata,
    input  logic [511:0]        rx_data,
    ctrl_resp_if.to_host        ctrl_resp,
    output logic                stall,
    output logic [31:0]         run_rsp_count,
    output logic                run_complete,
    output logic                err_unexpected
);
    localparam int AW = $bits(t_cci_clAddr);

    t_rx_stage                        s1;
    logic [$clog2(MAX_OUTSTANDING):0] outstanding;
    logic                             underflow;
    logic [32:0]                      expected;
    logic [31:0]                      count_inc;
    logic                             run_hit;
    logic                             run_over;
    logic                             unused_line;

    assign unused_line = ^rx_data[511:CTRL_RD_ADDR_LSB + AW];

    credit_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .STALL_MARGIN    (STALL_MARGIN)
    ) u_credit (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (rd_issued),
        .dec       (rx_valid),
        .almfull   (tx_almfull),
        .count     (outstanding),
        .stall     (stall),
        .underflow (underflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
        end else begin
            s1.valid   <= rx_valid;
            s1.mdata   <= rx_mdata;
            s1.code    <= rx_data[CTRL_CODE_LSB +: 32];
            s1.num_cls <= rx_data[CTRL_NUM_CLS_LSB +: 32];
            s1.rd_addr <= rx_data[CTRL_RD_ADDR_LSB +: AW];
        end
    end

    // A response only completes the run when it moves the count onto expected from below.
    always_comb begin
        count_inc = (run_rsp_count == 32'hFFFF_FFFF) ? run_rsp_count : run_rsp_count + 32'd1;
        run_hit   = ({1'b0, count_inc} == expected) && ({1'b0, run_rsp_count} < expected);
        run_over  = {1'b0, run_rsp_count} >= expected;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_resp.valid   <= 1'b0;
            ctrl_resp.ack     <= 1'b0;
            ctrl_resp.code    <= '0;
            ctrl_resp.rd_addr <= '0;
            ctrl_resp.num_cls <= '0;
            expected          <= '0;
            run_rsp_count     <= '0;
            run_complete      <= 1'b0;
            err_unexpected    <= 1'b0;
        end else begin
            ctrl_resp.ack   <= 1'b0;
            ctrl_resp.valid <= 1'b0;
            run_complete    <= 1'b0;
            if (underflow) err_unexpected <= 1'b1;
            if (s1.valid) begin
                if (s1.mdata == READ_CTRL_MDATA) begin
                    ctrl_resp.ack <= 1'b1;
                    if (s1.code != CONTROL_NOP) begin
                        ctrl_resp.valid   <= 1'b1;
                        ctrl_resp.code    <= s1.code;
                        ctrl_resp.rd_addr <= s1.rd_addr;
                        ctrl_resp.num_cls <= s1.num_cls;
                        // The issuer covers start..start+num_cls inclusive, hence one extra line.
                        if (s1.code == CONTROL_START_RUN) begin
                            expected      <= {1'b0, s1.num_cls} + 33'd1;
                            run_rsp_count <= '0;
                        end
                    end
                end else if (s1.mdata == READ_RUN_MDATA) begin
                    run_rsp_count <= count_inc;
                    if (run_hit && completion_allowed(afu_state)) run_complete <= 1'b1;
                    if (run_over) err_unexpected <= 1'b1;
                end else begin
                    err_unexpected <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_read_response_handler.sv
// Self-checking bench for read_response_handler: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level reference model.
module tb_read_response_handler;
    import afu_base::*;
    import interface_debug::*;

    localparam int MAX_OUTSTANDING = 64;
    localparam int STALL_MARGIN    = 4;
    localparam int COUNT_CEIL      = 2 * MAX_OUTSTANDING - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    e_afu_state   afu_state = AFU_IDLE;
    logic         rd_issued = 1'b0;
    logic         tx_almfull = 1'b0;
    logic         rx_valid = 1'b0;
    t_cci_mdata   rx_mdata = '0;
    logic [511:0] rx_data = '0;
    logic         stall;
    logic [31:0]  run_rsp_count;
    logic         run_complete;
    logic         err_unexpected;

    ctrl_resp_if ctrl_resp();

    read_response_handler #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .STALL_MARGIN    (STALL_MARGIN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .afu_state      (afu_state),
        .rd_issued      (rd_issued),
        .tx_almfull     (tx_almfull),
        .rx_valid       (rx_valid),
        .rx_mdata       (rx_mdata),
        .rx_data        (rx_data),
        .ctrl_resp      (ctrl_resp),
        .stall          (stall),
        .run_rsp_count  (run_rsp_count),
        .run_complete   (run_complete),
        .err_unexpected (err_unexpected)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [15:0] mdata;
        logic [31:0] code;
        logic [31:0] num;
        logic [41:0] addr;
    } t_rsp;

    t_rsp pend[$];

    int checks = 0;
    int passed = 0;

    // Reference model state, updated one transaction at a time.
    int          m_out;
    bit          m_err;
    bit          m_stall;
    longint      m_expected;
    longint      m_count;
    bit          m_ack;
    bit          m_valid;
    bit          m_complete;
    logic [31:0] m_code;
    logic [31:0] m_num;
    logic [41:0] m_addr;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    endtask

    function automatic t_rsp no_rsp();
        t_rsp r = '0;
        return r;
    endfunction

    function automatic t_rsp ctrl_rsp(input logic [31:0] code, input logic [31:0] num, input logic [41:0] addr);
        t_rsp r = '0;
        r.valid = 1'b1;
        r.mdata = READ_CTRL_MDATA;
        r.code  = code;
        r.num   = num;
        r.addr  = addr;
        return r;
    endfunction

    function automatic t_rsp other_rsp(input logic [15:0] mdata);
        t_rsp r = '0;
        r.valid = 1'b1;
        r.mdata = mdata;
        return r;
    endfunction

    function automatic logic [511:0] line_of(input t_rsp r);
        logic [511:0] line;
        for (int i = 0; i < 16; i++) line[i*32 +: 32] = $urandom;
        if (r.mdata == READ_CTRL_MDATA) begin
            line[31:0]   = r.code;
            line[63:32]  = r.num;
            line[105:64] = r.addr;
        end
        return line;
    endfunction

    task automatic checkAll();
        checkOutput("ack", ctrl_resp.ack, m_ack);
        checkOutput("valid", ctrl_resp.valid, m_valid);
        checkOutput("code", ctrl_resp.code, m_code);
        checkOutput("num_cls", ctrl_resp.num_cls, m_num);
        checkOutput("rd_addr", ctrl_resp.rd_addr, m_addr);
        checkOutput("run_rsp_count", run_rsp_count, m_count);
        checkOutput("run_complete", run_complete, m_complete);
        checkOutput("err_unexpected", err_unexpected, m_err);
        checkOutput("stall", stall, m_stall);
        checkOutput("outstanding", dut.outstanding, m_out);
    endtask

    task automatic modelResponse(input t_rsp r, input e_afu_state st);
        longint prior;
        if (!r.valid) return;
        if (r.mdata == READ_CTRL_MDATA) begin
            m_ack = 1;
            if (r.code != 0) begin
                m_valid = 1;
                m_code  = r.code;
                m_num   = r.num;
                m_addr  = r.addr;
                if (r.code == 1) begin
                    m_expected = longint'(r.num) + 1;
                    m_count    = 0;
                end
            end
        end else if (r.mdata == READ_RUN_MDATA) begin
            prior = m_count;
            if (m_count < 64'hFFFF_FFFF) m_count++;
            if (prior >= m_expected) m_err = 1;
            else if (m_count == m_expected && (st == AFU_CTRL || st == AFU_RUN)) m_complete = 1;
        end else begin
            m_err = 1;
        end
    endtask

    // One clock of stimulus; outputs are checked 1 time unit after the edge.
    task automatic applyStimulus(input logic issue, input logic almfull, input t_rsp rsp, input e_afu_state st);
        t_rsp old;
        rd_issued  = issue;
        tx_almfull = almfull;
        afu_state  = st;
        rx_valid   = rsp.valid;
        rx_mdata   = rsp.mdata;
        rx_data    = line_of(rsp);
        @(posedge clk);
        #1;
        if (issue && !rsp.valid) begin
            if (m_out < COUNT_CEIL) m_out++;
        end else if (rsp.valid && !issue) begin
            if (m_out == 0) m_err = 1;
            else m_out--;
        end
        m_stall = almfull || (m_out >= MAX_OUTSTANDING - STALL_MARGIN);
        m_ack = 0;
        m_valid = 0;
        m_complete = 0;
        pend.push_back(rsp);
        if (pend.size() > 1) begin
            old = pend.pop_front();
            modelResponse(old, st);
        end
        checkAll();
    endtask

    task automatic doReset(input int hold_cycles);
        rst_n      = 1'b0;
        rd_issued  = 1'b0;
        rx_valid   = 1'b0;
        tx_almfull = 1'b0;
        #1;
        m_out = 0; m_err = 0; m_stall = 1; m_expected = 0; m_count = 0;
        m_ack = 0; m_valid = 0; m_complete = 0; m_code = 0; m_num = 0; m_addr = 0;
        pend.delete();
        checkAll();
        repeat (hold_cycles) begin
            @(posedge clk);
            #1;
        end
        checkAll();
        rst_n = 1'b1;
    endtask

    task automatic randomPhase(input int cycles);
        int          sel;
        logic        issue;
        logic        almfull;
        t_rsp        r;
        e_afu_state  st;
        logic [41:0] addr;
        for (int i = 0; i < cycles; i++) begin
            sel     = $urandom_range(0, 99);
            issue   = (m_out < 100) && ($urandom_range(0, 99) < 55);
            almfull = ($urandom_range(0, 9) == 0);
            st      = ($urandom_range(0, 9) == 0) ? AFU_IDLE : AFU_RUN;
            addr    = {$urandom, $urandom};
            r       = no_rsp();
            if (m_out > 0 && sel < 45) r = other_rsp(READ_RUN_MDATA);
            else if (m_out > 0 && sel < 55) r = ctrl_rsp($urandom_range(0, 2), $urandom_range(0, 6), addr);
            else if (sel == 99) r = other_rsp(16'h1000 + 16'($urandom_range(0, 255)));
            applyStimulus(issue, almfull, r, st);
        end
    endtask

    initial begin
        #1;
        doReset(2);

        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, no_rsp(), AFU_CTRL);
        applyStimulus(1'b0, 1'b0, ctrl_rsp(CONTROL_START_RUN, 32'd7, 42'h1000), AFU_CTRL);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, other_rsp(READ_RUN_MDATA), AFU_RUN);
        applyStimulus(1'b0, 1'b0, no_rsp(), AFU_RUN);
        checkOutput("run_complete_on_8th", run_complete, 1);
        checkOutput("run_count_8", run_rsp_count, 8);

        applyStimulus(1'b0, 1'b0, ctrl_rsp(CONTROL_NOP, 32'h55, 42'h77), AFU_CTRL);
        applyStimulus(1'b0, 1'b0, no_rsp(), AFU_CTRL);
        checkOutput("nop_ack", ctrl_resp.ack, 1);
        checkOutput("nop_valid", ctrl_resp.valid, 0);
        checkOutput("nop_holds_addr", ctrl_resp.rd_addr, 42'h1000);

        for (int i = 0; i < 49; i++) applyStimulus(1'b1, 1'b0, no_rsp(), AFU_RUN);
        checkOutput("stall_at_59", stall, 0);
        applyStimulus(1'b1, 1'b0, no_rsp(), AFU_RUN);
        checkOutput("stall_at_60", stall, 1);
        applyStimulus(1'b0, 1'b0, ctrl_rsp(CONTROL_NOP, 0, 0), AFU_RUN);
        checkOutput("stall_after_rsp", stall, 0);
        applyStimulus(1'b1, 1'b0, ctrl_rsp(CONTROL_NOP, 0, 0), AFU_RUN);
        checkOutput("issue_and_rsp_same_cycle", dut.outstanding, 59);
        applyStimulus(1'b0, 1'b1, no_rsp(), AFU_RUN);
        applyStimulus(1'b0, 1'b0, no_rsp(), AFU_RUN);

        applyStimulus(1'b0, 1'b0, ctrl_rsp(CONTROL_START_RUN, 32'hFFFF_FFFF, 42'h2000), AFU_RUN);
        applyStimulus(1'b0, 1'b0, other_rsp(READ_RUN_MDATA), AFU_RUN);
        applyStimulus(1'b0, 1'b0, no_rsp(), AFU_RUN);
        checkOutput("no_wrap_complete", run_complete, 0);
        checkOutput("no_wrap_count", run_rsp_count, 1);
        checkOutput("no_err_yet", err_unexpected, 0);

        while (m_out > 14) applyStimulus(1'b0, 1'b0, ctrl_rsp(CONTROL_NOP, 0, 0), AFU_RUN);
        applyStimulus(1'b0, 1'b0, ctrl_rsp(CONTROL_START_RUN, 32'd20, 42'h3000), AFU_RUN);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, other_rsp(READ_RUN_MDATA), AFU_RUN);
        checkOutput("outstanding_before_reset", dut.outstanding, 10);
        doReset(2);
        applyStimulus(1'b0, 1'b0, no_rsp(), AFU_RUN);
        checkOutput("stall_after_release", stall, 0);
        applyStimulus(1'b0, 1'b0, other_rsp(READ_RUN_MDATA), AFU_RUN);
        applyStimulus(1'b0, 1'b0, no_rsp(), AFU_RUN);
        checkOutput("straggler_after_reset", err_unexpected, 1);

        doReset(1);
        applyStimulus(1'b0, 1'b0, ctrl_rsp(CONTROL_NOP, 0, 0), AFU_CTRL);
        checkOutput("underflow_err", err_unexpected, 1);
        checkOutput("underflow_holds_zero", dut.outstanding, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, no_rsp(), AFU_CTRL);

        doReset(1);
        applyStimulus(1'b1, 1'b0, no_rsp(), AFU_CTRL);
        applyStimulus(1'b0, 1'b0, other_rsp(16'hBEEF), AFU_CTRL);
        applyStimulus(1'b0, 1'b0, no_rsp(), AFU_CTRL);
        checkOutput("bad_mdata_err", err_unexpected, 1);
        checkOutput("bad_mdata_outstanding", dut.outstanding, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, no_rsp(), AFU_CTRL);

        doReset(1);
        randomPhase(3000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
